// File: rtl/unfilter_pipe.sv
// unfilter_pipe: elastic inverse of the Filter encoder chain.
// Each stage rotates the {parity,data} word right by one bit as it enters the stage register.
module unfilter_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_y_data,
    input  logic             io_y_parity,
    input  logic             io_y_valid,
    output logic             io_y_ready,
    output logic [WIDTH-1:0] io_x_data,
    output logic             io_x_parity,
    output logic             io_x_valid,
    input  logic             io_x_ready,
    output logic [15:0]      io_count
);
    localparam int unsigned CNT_W = 16;

    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0]            r_parity;
    logic [STAGES-1:0][WIDTH-1:0] r_data;
    logic [CNT_W-1:0]             r_count;

    logic [STAGES-1:0]            w_ready;
    logic [STAGES-1:0]            w_src_valid;
    logic [STAGES-1:0]            w_src_parity;
    logic [STAGES-1:0][WIDTH-1:0] w_src_data;
    logic [STAGES-1:0][WIDTH-1:0] w_nxt_data;
    logic [STAGES-1:0]            w_nxt_parity;
    logic                         w_out_fire;

    // Stage k can load when any stage from k downstream holds a bubble or the consumer drains.
    always_comb begin
        logic v_acc;
        w_ready = '0;
        v_acc   = 1'b0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            v_acc = io_x_ready;
            for (int unsigned j = k; j < STAGES; j++) begin
                v_acc = v_acc | ~r_valid[j];
            end
            w_ready[k] = v_acc;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_src_valid[g]  = io_y_valid;
            assign w_src_parity[g] = io_y_parity;
            assign w_src_data[g]   = io_y_data;
        end else begin : g_chain
            assign w_src_valid[g]  = r_valid[g-1];
            assign w_src_parity[g] = r_parity[g-1];
            assign w_src_data[g]   = r_data[g-1];
        end
        assign w_nxt_data[g]   = {w_src_parity[g], w_src_data[g][WIDTH-1:1]};
        assign w_nxt_parity[g] = w_src_data[g][0];
    end

    assign w_out_fire = r_valid[STAGES-1] & io_x_ready;

    // Stage registers and handshake counter; reset wins over any concurrent handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            r_parity <= '0;
            r_data   <= '0;
            r_count  <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k]  <= w_src_valid[k];
                    r_parity[k] <= w_nxt_parity[k];
                    r_data[k]   <= w_nxt_data[k];
                end
            end
            if (w_out_fire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign io_y_ready  = w_ready[0];
    assign io_x_valid  = r_valid[STAGES-1];
    assign io_x_data   = r_data[STAGES-1];
    assign io_x_parity = r_parity[STAGES-1];
    assign io_count    = r_count;

endmodule

// File: tb/tb_unfilter_pipe.sv
// Self-checking bench for unfilter_pipe: scoreboard of expected decoded words plus per-scenario checks.
module tb_unfilter_pipe;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] io_y_data;
    logic             io_y_parity;
    logic             io_y_valid;
    logic             io_y_ready;
    logic [WIDTH-1:0] io_x_data;
    logic             io_x_parity;
    logic             io_x_valid;
    logic             io_x_ready;
    logic [15:0]      io_count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [16:0] sb_q[$];

    unfilter_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset),
        .io_y_data(io_y_data), .io_y_parity(io_y_parity),
        .io_y_valid(io_y_valid), .io_y_ready(io_y_ready),
        .io_x_data(io_x_data), .io_x_parity(io_x_parity),
        .io_x_valid(io_x_valid), .io_x_ready(io_x_ready),
        .io_count(io_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Expected decode: rotate the 17-bit {parity,data} word right by STAGES.
    function automatic logic [16:0] model(input logic [15:0] d, input logic p);
        logic [33:0] ww;
        ww = {p, d, p, d} >> STAGES;
        return ww[16:0];
    endfunction

    // One Filter encoder stage: rotate {parity,data} left by one.
    function automatic logic [16:0] encode(input logic [16:0] w);
        return {w[15:0], w[16]};
    endfunction

    // Output monitor: every output handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && io_x_valid && io_x_ready) begin
            logic [16:0] exp_w;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got %h with nothing expected", {io_x_parity, io_x_data});
            end else begin
                exp_w = sb_q.pop_front();
                if ({io_x_parity, io_x_data} !== exp_w) begin
                    miscompares++;
                    $display("FAIL sb_word: got %h expected %h", {io_x_parity, io_x_data}, exp_w);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        io_y_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic idle(input int n);
        io_y_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic p, input logic [16:0] exp_w);
        int   guard;
        logic acc;
        io_y_data   = d;
        io_y_parity = p;
        io_y_valid  = 1'b1;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = io_y_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (acc) begin
            sb_q.push_back(exp_w);
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: word %h not accepted in 100 cycles", d);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vectors++;
        if ({io_x_valid, io_x_parity, io_x_data, io_y_ready} !== {1'b0, 1'b0, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b par=%b data=%h yready=%b", io_x_valid, io_x_parity, io_x_data, io_y_ready);
        end
        vectors++;
        if (io_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_count: got %h expected 0000", io_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        send(16'h8001, 1'b1, {1'b0, 16'hE000});
        io_y_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (io_x_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: x_valid=%b expected 0 one cycle after accept", io_x_valid);
        end
        @(negedge clk);
        vectors++;
        if ({io_x_valid, io_x_parity, io_x_data} !== {1'b1, 1'b0, 16'hE000}) begin
            miscompares++;
            $display("FAIL single_out: valid=%b par=%b data=%h expected 1 0 e000", io_x_valid, io_x_parity, io_x_data);
        end
        @(negedge clk);
        vectors++;
        if ({io_x_valid, io_count} !== {1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL single_after: valid=%b count=%0d expected 0 1", io_x_valid, io_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip();
        logic [16:0] orig;
        logic [16:0] enc;
        orig = {1'b1, 16'h1234};
        enc  = orig;
        for (int s = 0; s < STAGES; s++) enc = encode(enc);
        send(enc[15:0], enc[16], orig);
        for (int i = 0; i < 1000; i++) begin
            orig = 17'($urandom);
            enc  = orig;
            for (int s = 0; s < STAGES; s++) enc = encode(enc);
            send(enc[15:0], enc[16], orig);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(STAGES + 2);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL round_trip_drain: %0d words still expected", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w[8];
        logic [15:0] cnt0;
        cnt0 = io_count;
        for (int i = 0; i < 8; i++) w[i] = 16'hA000 + 16'(i * 16'h0111);
        fork
            begin
                for (int i = 0; i < 8; i++) send(w[i], 1'(i), model(w[i], 1'(i)));
                io_y_valid = 1'b0;
            end
            begin
                logic [16:0] held;
                logic [16:0] want;
                repeat (3) @(posedge clk);
                #1 io_x_ready = 1'b0;
                want = model(w[1], 1'b1);
                held = '0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) held = {io_x_parity, io_x_data};
                    vectors++;
                    if ({io_y_ready, io_x_valid, io_x_parity, io_x_data} !== {1'b0, 1'b1, want}) begin
                        miscompares++;
                        $display("FAIL stall_hold: yready=%b valid=%b word=%h held=%h expected yready 0 valid 1 word %h",
                                 io_y_ready, io_x_valid, {io_x_parity, io_x_data}, held, want);
                    end
                end
                @(posedge clk);
                #1 io_x_ready = 1'b1;
            end
        join
        idle(STAGES + 3);
        vectors++;
        if (sb_q.size() != 0 || io_count !== 16'(cnt0 + 16'd8)) begin
            miscompares++;
            $display("FAIL stall_drain: left=%0d count=%0d expected 0 and %0d", sb_q.size(), io_count, cnt0 + 16'd8);
        end
    endtask

    task automatic test_throughput();
        int run;
        int c0;
        int c1;
        do_reset();
        run = 0;
        c0 = 0;
        c1 = 0;
        fork
            begin
                c0 = cyc;
                for (int i = 0; i < 20; i++) begin
                    logic [15:0] d;
                    d = 16'($urandom);
                    send(d, 1'(i), model(d, 1'(i)));
                end
                c1 = cyc;
                io_y_valid = 1'b0;
            end
            begin
                int guard;
                guard = 0;
                @(negedge clk);
                while (!io_x_valid && guard < 30) begin
                    @(negedge clk);
                    guard++;
                end
                for (int i = 0; i < 20; i++) begin
                    if (io_x_valid && io_x_ready) run++;
                    @(negedge clk);
                end
            end
        join
        vectors++;
        if (c1 - c0 != 20) begin
            miscompares++;
            $display("FAIL tput_accept: 20 words took %0d cycles expected 20", c1 - c0);
        end
        vectors++;
        if (run != 20) begin
            miscompares++;
            $display("FAIL tput_consecutive: %0d consecutive outputs expected 20", run);
        end
        idle(STAGES + 2);
        vectors++;
        if (io_count !== 16'd20) begin
            miscompares++;
            $display("FAIL tput_count: got %0d expected 20", io_count);
        end
    endtask

    task automatic test_reset_mid();
        send(16'h5555, 1'b0, model(16'h5555, 1'b0));
        send(16'h0F0F, 1'b1, model(16'h0F0F, 1'b1));
        io_y_valid = 1'b0;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({io_x_valid, io_x_data, io_count, io_y_ready} !== {1'b0, 16'h0000, 16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b data=%h count=%h yready=%b expected 0 0000 0000 1",
                     io_x_valid, io_x_data, io_count, io_y_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (io_x_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ghost: x_valid=%b expected 0 at cycle %0d after reset", io_x_valid, i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            send(d, d[3], model(d, d[3]));
        end
        idle(STAGES + 2);
        vectors++;
        if (io_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h expected ffff", io_count);
        end
        send(16'hBEEF, 1'b0, model(16'hBEEF, 1'b0));
        idle(STAGES + 2);
        vectors++;
        if (io_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_rollover: got %h expected 0000", io_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        io_y_data   = '0;
        io_y_parity = 1'b0;
        io_y_valid  = 1'b0;
        io_x_ready  = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_round_trip();
        test_backpressure();
        test_throughput();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
